sys_cmd_decoder: RTL and testbench

- Receive-side command controller for the system control path.
- Consumes bytes from the UART receiver and decodes four framed commands: register write, register read, ALU op with operands, ALU op without operands.
- Sequences the register file and the ALU, then hands each response to the transmit-side response controller through the `fsm2_start`/`valid`/`fsm1_state` handshake.
- Waits until that controller returns to idle before accepting the next command.

---
 rtl/sys_cmd_pkg.sv | 29 ++
 rtl/sys_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared constants for the receive-side command decoder: opcodes, the
// externally visible 6-bit state codes and the fixed ALU operand addresses.
package sys_cmd_pkg;

    localparam logic [7:0] OPC_WR     = 8'hAA;
    localparam logic [7:0] OPC_RD     = 8'hBB;
    localparam logic [7:0] OPC_ALU    = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    // Codes are exported on fsm1_state, so the encoding is fixed.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000000,
        ST_WR_ADDR   = 6'b000001,
        ST_WR_DATA   = 6'b000010,
        ST_OP_A      = 6'b000011,
        ST_RD_ADDR   = 6'b000100,
        ST_RD_ISSUE  = 6'b000101,
        ST_OP_B      = 6'b000110,
        ST_ALU_EXEC  = 6'b000111,
        ST_OP_FUN    = 6'b001000,
        ST_NOP_FUN   = 6'b001001,
        ST_NOP_EXEC  = 6'b001010,
        ST_RESP_WAIT = 6'b001011
    } state_e;

endpackage

// File: rtl/sys_cmd_decoder.sv
// Decodes framed UART commands into register-file writes/reads and ALU runs,
// then holds off new commands until the response controller is idle again.
module sys_cmd_decoder
    import sys_cmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) (
    input  logic              clck,
    input  logic              rst,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              resp_busy,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic [DATA_W-1:0] WrData,
    output logic              RdEn,
    output logic [FUN_W-1:0]  ALU_FUN,
    output logic              ALU_EN,
    output logic              CLK_GATE_EN,
    output logic              fsm2_start,
    output logic              valid,
    output logic [5:0]        fsm1_state
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FUN_W-1:0]  fun_q, fun_d;
    logic              alu_cmd_q, alu_cmd_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_issue, exec;

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            fun_q     <= '0;
            alu_cmd_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            fun_q     <= fun_d;
            alu_cmd_q <= alu_cmd_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        fun_d     = fun_q;
        alu_cmd_d = alu_cmd_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_W'(OPC_WR)) begin
                        state_d = ST_WR_ADDR;
                    end else if (RX_P_DATA == DATA_W'(OPC_RD)) begin
                        state_d = ST_RD_ADDR;
                    end else if (RX_P_DATA == DATA_W'(OPC_ALU)) begin
                        state_d   = ST_OP_A;
                        alu_cmd_d = 1'b1;
                    end else if (RX_P_DATA == DATA_W'(OPC_ALU_NO)) begin
                        state_d   = ST_NOP_FUN;
                        alu_cmd_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = RX_P_DATA;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_d = ST_RESP_WAIT;
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(OPA_ADDR);
                    wr_data_d = RX_P_DATA;
                    state_d   = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(OPB_ADDR);
                    wr_data_d = RX_P_DATA;
                    state_d   = ST_OP_FUN;
                end
            end
            ST_OP_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[FUN_W-1:0];
                    state_d = ST_ALU_EXEC;
                end
            end
            ST_NOP_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[FUN_W-1:0];
                    state_d = ST_NOP_EXEC;
                end
            end
            ST_ALU_EXEC,
            ST_NOP_EXEC:  state_d = ST_RESP_WAIT;
            ST_RESP_WAIT: if (!resp_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // The ALU-pending flag only lives for the duration of one command.
        if (state_d == ST_IDLE) alu_cmd_d = 1'b0;
    end

    assign rd_issue = (state_q == ST_RD_ISSUE);
    assign exec     = (state_q == ST_ALU_EXEC) || (state_q == ST_NOP_EXEC);

    // Write and read address never coincide: no write is pending in RD_ISSUE.
    assign Address     = wr_en_q ? wr_addr_q : (rd_issue ? addr_q : '0);
    assign WrEn        = wr_en_q;
    assign WrData      = wr_en_q ? wr_data_q : '0;
    assign RdEn        = rd_issue;
    assign ALU_EN      = exec;
    assign ALU_FUN     = fun_q;
    assign fsm2_start  = rd_issue || exec;
    assign valid       = rd_issue || exec;
    assign fsm1_state  = state_q;
    assign CLK_GATE_EN = exec
                      || (state_q == ST_OP_FUN) || (state_q == ST_NOP_FUN)
                      || ((state_q == ST_RESP_WAIT) && alu_cmd_q);

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Randomized frame-level bench for sys_cmd_decoder: expected strobes are
// derived from the command frame contents, not from the decoder's state logic.
module tb_sys_cmd_decoder;

    logic       clck = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD  = 1'b0;
    logic       resp_busy = 1'b0;
    logic [3:0] Address;
    logic       WrEn;
    logic [7:0] WrData;
    logic       RdEn;
    logic [3:0] ALU_FUN;
    logic       ALU_EN;
    logic       CLK_GATE_EN;
    logic       fsm2_start;
    logic       valid;
    logic [5:0] fsm1_state;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_fun = '0;

    always #5 clck = ~clck;

    sys_cmd_decoder #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) dut (
        .clck(clck), .rst(rst), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .resp_busy(resp_busy), .Address(Address), .WrEn(WrEn), .WrData(WrData),
        .RdEn(RdEn), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
        .fsm2_start(fsm2_start), .valid(valid), .fsm1_state(fsm1_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte strobe after a random gap; checks the write strobe the frame implies.
    task automatic send(input logic [7:0] b, input logic ew, input logic [3:0] ea, input logic [7:0] ed);
        repeat ($urandom_range(0, 2)) @(negedge clck);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge clck);
        #1 RX_D_VLD = 1'b0;
        @(negedge clck);
        chk("wr_en", WrEn, ew);
        if (ew) begin
            chk("wr_addr", Address, ea);
            chk("wr_data", WrData, ed);
        end
    endtask

    task automatic chk_start(input logic [5:0] st, input logic rd, input logic alu, input logic [3:0] ad);
        chk("start_state", fsm1_state, st);
        chk("fsm2_start", fsm2_start, 1'b1);
        chk("valid", valid, 1'b1);
        chk("rd_en", RdEn, rd);
        chk("alu_en", ALU_EN, alu);
        chk("clk_gate_exec", CLK_GATE_EN, alu);
        chk("alu_fun", ALU_FUN, exp_fun);
        if (rd) chk("rd_addr", Address, ad);
    endtask

    // Response handshake: entered at the negedge of the issue/exec cycle.
    task automatic resp_phase(input logic alu);
        int k, w;
        k = $urandom_range(0, 3);
        w = (k > 0) ? k : 1;
        resp_busy = (k > 0);
        if ($urandom_range(0, 1) == 1) begin
            RX_P_DATA = 8'hBB;
            RX_D_VLD  = 1'b1;
        end
        for (int i = 0; i < w; i++) begin
            @(posedge clck);
            #1 RX_D_VLD = 1'b0;
            @(negedge clck);
            chk("resp_wait_state", fsm1_state, 6'b001011);
            chk("resp_wait_gate", CLK_GATE_EN, alu);
            chk("resp_wait_start", fsm2_start, 1'b0);
            chk("resp_wait_strobes", {RdEn, ALU_EN, WrEn}, 3'b000);
            if (i == w - 1) resp_busy = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                RX_P_DATA = 8'hBB;
                RX_D_VLD  = 1'b1;
            end
        end
        @(posedge clck);
        #1 RX_D_VLD = 1'b0;
        @(negedge clck);
        chk("back_idle", fsm1_state, 6'b000000);
        chk("idle_gate", CLK_GATE_EN, 1'b0);
        chk("idle_fun_hold", ALU_FUN, exp_fun);
    endtask

    // kind: 0=write, 1=read, 2=ALU with operands, 3=ALU without operands
    task automatic run_cmd(input int kind, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        case (kind)
            0: begin
                send(8'hAA, 1'b0, 4'h0, 8'h00);
                send(p0, 1'b0, 4'h0, 8'h00);
                send(p1, 1'b1, p0[3:0], p1);
                chk("wr_state_idle", fsm1_state, 6'b000000);
                chk("wr_no_start", fsm2_start, 1'b0);
                @(negedge clck);
                chk("wr_single_pulse", WrEn, 1'b0);
            end
            1: begin
                send(8'hBB, 1'b0, 4'h0, 8'h00);
                send(p0, 1'b0, 4'h0, 8'h00);
                chk_start(6'b000101, 1'b1, 1'b0, p0[3:0]);
                resp_phase(1'b0);
            end
            2: begin
                send(8'hCC, 1'b0, 4'h0, 8'h00);
                send(p0, 1'b1, 4'h0, p0);
                send(p1, 1'b1, 4'h1, p1);
                exp_fun = p2[3:0];
                send(p2, 1'b0, 4'h0, 8'h00);
                chk_start(6'b000111, 1'b0, 1'b1, 4'h0);
                resp_phase(1'b1);
            end
            default: begin
                send(8'hDD, 1'b0, 4'h0, 8'h00);
                exp_fun = p0[3:0];
                send(p0, 1'b0, 4'h0, 8'h00);
                chk_start(6'b001010, 1'b0, 1'b1, 4'h0);
                resp_phase(1'b1);
            end
        endcase
    endtask

    task automatic junk();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
        send(b, 1'b0, 4'h0, 8'h00);
        chk("junk_idle", fsm1_state, 6'b000000);
        chk("junk_no_start", fsm2_start, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, fsm1_state, 6'b000000);
        chk({tag, "_outs"}, {WrEn, RdEn, ALU_EN, CLK_GATE_EN, fsm2_start, valid}, 6'b000000);
        chk({tag, "_fun"}, ALU_FUN, 4'h0);
        chk({tag, "_addr"}, Address, 4'h0);
        chk({tag, "_data"}, WrData, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clck);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clck);

        run_cmd(0, 8'h05, 8'h3C, 8'h00);
        run_cmd(1, 8'h07, 8'h00, 8'h00);
        run_cmd(2, 8'h12, 8'h34, 8'h01);
        run_cmd(3, 8'h03, 8'h00, 8'h00);
        run_cmd(0, 8'hF9, 8'h81, 8'h00);
        junk();

        // Reset right after the first operand is accepted: the write must vanish.
        send(8'hCC, 1'b0, 4'h0, 8'h00);
        RX_P_DATA = 8'h12;
        RX_D_VLD  = 1'b1;
        @(posedge clck);
        #1 RX_D_VLD = 1'b0;
        rst = 1'b0;
        exp_fun = 4'h0;
        #1 chk_all_zero("midframe_rst");
        @(negedge clck);
        chk_all_zero("midframe_rst_hold");
        rst = 1'b1;
        run_cmd(0, 8'h09, 8'hA5, 8'h00);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) junk();
            run_cmd(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
